decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 o1  output  16  registered one-hot decode result; bit i set means the input code equals i.
REQ-006 e  input  1  code bit 3, the MSB of the 4-bit select.
REQ-007 x  input  1  code bit 2.
REQ-008 y  input  1  code bit 1.
REQ-009 z  input  1  code bit 0, the LSB of the 4-bit select.
REQ-010 Positional port order SHALL be o1, e, x, y, z, clk, rst_n, so existing positional instantiations of the first five ports remain valid.

Function
REQ-011 The select code SHALL be sel = {e, x, y, z}, giving an unsigned value of 0..15.
REQ-012 On each rising clk edge with rst_n=1, o1 SHALL load a 16-bit word with bit sel set to 1 and all other bits 0.
REQ-013 Latency SHALL be exactly one clock cycle from sampled inputs to o1; there is no combinational path from the inputs to o1.
REQ-014 Outside reset, exactly one bit of o1 SHALL be 1 in every cycle (popcount = 1); there are no idle or all-zero states.
REQ-015 e SHALL act purely as the code MSB, not as an enable:
- e=0 selects o1[7:0].
- e=1 selects o1[15:8].
REQ-016 Inputs changing between clock edges SHALL have no effect on o1 until the next rising edge.
REQ-017 Inputs SHALL be used as sampled, with no handshake, no state machine and no input buffering.
REQ-018 If any input is X or Z at the sampling edge, o1 SHALL load 16'h0000.
REQ-019 There is no wrap-around or overflow case: all 16 codes map one-to-one onto the 16 output bits.

Reset
REQ-020 When rst_n=0 at a rising clk edge, o1 SHALL load 16'h0000, regardless of e, x, y and z.
REQ-021 Reset SHALL take priority over decoding in the same cycle, including when asserted mid-sequence.
REQ-022 o1 SHALL remain 16'h0000 while rst_n is held low.
REQ-023 On the first rising edge with rst_n=1, o1 SHALL take the decode of the inputs sampled at that edge.
REQ-024 Asynchronous behaviour on rst_n is forbidden: a rst_n pulse that does not span a rising edge SHALL leave o1 unchanged.
REQ-025 Before the first reset, o1 is undefined, and benches SHALL apply reset first.

Verification
REQ-026 The bench SHALL cover exhaustive sweep: reset, then apply {e,x,y,z} = 0..15 one per cycle -> one cycle later o1 = 1<<sel each time, from 16'h0001 through 16'h8000.
REQ-027 The bench SHALL cover MSB handling: e=0,x=1,y=1,z=1 -> o1=16'h0080, then e=1,x=0,y=0,z=0 -> o1=16'h0100.
REQ-028 The bench SHALL cover reset priority: rst_n=0 with e=1,x=1,y=1,z=1 -> o1=16'h0000; release rst_n -> next edge o1=16'h8000.
REQ-029 The bench SHALL cover mid-sequence reset: o1=16'h0020, then assert rst_n for one edge -> o1=16'h0000, then resume -> correct decode one cycle later.
REQ-030 The bench SHALL cover latency and glitch checks:
- Toggle inputs between edges -> o1 changes only at rising edges, exactly one cycle after sampling.
- Popcount(o1) = 1 whenever the block is out of reset.
REQ-031 The bench SHALL cover the X-input case: z=X at a sampling edge -> o1=16'h0000; on the next valid code, normal one-hot output resumes.

Source files
------------

// File: rtl/decoder.sv
// Registered 4-to-16 one-hot decoder: o1 shows the one-hot decode of {e,x,y,z}
// one clock after the inputs are sampled. It clears synchronously while rst_n is low.
module decoder (
  output logic [15:0] o1,
  input  logic        e,
  input  logic        x,
  input  logic        y,
  input  logic        z,
  input  logic        clk,
  input  logic        rst_n
);

  logic [3:0]  sel;
  logic [15:0] decode_next;
  logic [15:0] o1_reg;

  assign sel = {e, x, y, z};

  // Each code is listed explicitly. An X or Z in sel then matches no item
  // and falls to the all-zero default.
  always_comb begin
    decode_next = 16'h0000;
    case (sel)
      4'd0:    decode_next = 16'h0001;
      4'd1:    decode_next = 16'h0002;
      4'd2:    decode_next = 16'h0004;
      4'd3:    decode_next = 16'h0008;
      4'd4:    decode_next = 16'h0010;
      4'd5:    decode_next = 16'h0020;
      4'd6:    decode_next = 16'h0040;
      4'd7:    decode_next = 16'h0080;
      4'd8:    decode_next = 16'h0100;
      4'd9:    decode_next = 16'h0200;
      4'd10:   decode_next = 16'h0400;
      4'd11:   decode_next = 16'h0800;
      4'd12:   decode_next = 16'h1000;
      4'd13:   decode_next = 16'h2000;
      4'd14:   decode_next = 16'h4000;
      4'd15:   decode_next = 16'h8000;
      default: decode_next = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o1_reg <= 16'h0000;
    end else begin
      o1_reg <= decode_next;
    end
  end

  assign o1 = o1_reg;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder. A table of vectors covers reset, the full sweep,
// MSB handling and reset priority. Hand-written sequences cover the glitch, pulse and X cases.
module tb_decoder;

  logic [15:0] o1;
  logic        e, x, y, z;
  logic        clk;
  logic        rst_n;

  int errors = 0;
  int checks = 0;

  decoder dut (
    .o1    (o1),
    .e     (e),
    .x     (x),
    .y     (y),
    .z     (z),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  sel;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] s,
                              input logic [15:0] ex, input string nm);
    vec_t v;
    v.rst_n = r;
    v.sel   = s;
    v.exp   = ex;
    v.name  = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end else begin
      $display("ok   %s: o1=%h", nm, act);
    end
  endtask

  task automatic check_onehot(input string nm);
    checks++;
    if ($countones(o1) != 1 || $isunknown(o1)) begin
      errors++;
      $display("FAIL %s_popcount: actual=%0d required=1 (o1=%h)", nm, $countones(o1), o1);
    end
  endtask

  task automatic set_sel(input logic [3:0] s);
    {e, x, y, z} = s;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic        probe;
  logic        four_state;
  logic [15:0] x_exp;

  initial begin
    rst_n = 1'b0;
    set_sel(4'd0);

    add(1'b0, 4'd15, 16'h0000, "reset_sel15");
    add(1'b0, 4'd3,  16'h0000, "reset_held");
    add(1'b1, 4'd0,  16'h0001, "sweep_0");
    add(1'b1, 4'd1,  16'h0002, "sweep_1");
    add(1'b1, 4'd2,  16'h0004, "sweep_2");
    add(1'b1, 4'd3,  16'h0008, "sweep_3");
    add(1'b1, 4'd4,  16'h0010, "sweep_4");
    add(1'b1, 4'd5,  16'h0020, "sweep_5");
    add(1'b1, 4'd6,  16'h0040, "sweep_6");
    add(1'b1, 4'd7,  16'h0080, "sweep_7");
    add(1'b1, 4'd8,  16'h0100, "sweep_8");
    add(1'b1, 4'd9,  16'h0200, "sweep_9");
    add(1'b1, 4'd10, 16'h0400, "sweep_10");
    add(1'b1, 4'd11, 16'h0800, "sweep_11");
    add(1'b1, 4'd12, 16'h1000, "sweep_12");
    add(1'b1, 4'd13, 16'h2000, "sweep_13");
    add(1'b1, 4'd14, 16'h4000, "sweep_14");
    add(1'b1, 4'd15, 16'h8000, "sweep_15");
    add(1'b1, 4'd7,  16'h0080, "msb_e0_111");
    add(1'b1, 4'd8,  16'h0100, "msb_e1_000");
    add(1'b0, 4'd15, 16'h0000, "rst_prio_1111");
    add(1'b1, 4'd15, 16'h8000, "rst_release_1111");
    add(1'b1, 4'd5,  16'h0020, "mid_seq_5");
    add(1'b0, 4'd5,  16'h0000, "mid_seq_reset");
    add(1'b1, 4'd3,  16'h0008, "mid_seq_resume_3");
    add(1'b1, 4'd10, 16'h0400, "mid_seq_resume_10");

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      set_sel(vecs[i].sel);
      step();
      check(vecs[i].name, o1, vecs[i].exp);
      if (vecs[i].rst_n) check_onehot(vecs[i].name);
    end

    // Inputs toggle between edges. o1 may only follow the value present at the edge.
    rst_n = 1'b1;
    set_sel(4'd2);
    step();
    check("glitch_base", o1, 16'h0004);
    set_sel(4'd9);
    #1 check("glitch_no_comb_path", o1, 16'h0004);
    #2 set_sel(4'd4);
    #1 set_sel(4'd6);
    #1 check("glitch_hold", o1, 16'h0004);
    step();
    check("glitch_sampled_6", o1, 16'h0040);
    check_onehot("glitch_sampled_6");

    // A low pulse on rst_n that does not span an edge must do nothing.
    set_sel(4'd1);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("short_rst_pulse_async", o1, 16'h0040);
    step();
    check("short_rst_pulse_ignored", o1, 16'h0002);

    // X on z at the sampling edge. A 2-state simulator resolves the X to a
    // concrete level, so the expected value follows what was actually driven.
    probe = 1'bx;
    four_state = $isunknown(probe);
    e = 1'b0; x = 1'b0; y = 1'b1; z = 1'bx;
    x_exp = four_state ? 16'h0000 : (16'h0001 << {e, x, y, z});
    step();
    check("x_input", o1, x_exp);
    set_sel(4'd12);
    step();
    check("x_recover_12", o1, 16'h1000);
    check_onehot("x_recover_12");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
